// File: rtl/instr_encode_writer_if.sv
// Instruction-field handshake plus instruction-memory write port for instr_encode_writer.
// master: program source and memory side; slave: the encoder/writer.
interface instr_encode_writer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        output mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        input  mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encode_writer.sv
// Packs instruction fields into R/I/J words and writes them to consecutive memory words.
// Optional ENC_CHECKSUM_EN adds csum: XOR of every word accepted by memory.
module instr_encode_writer #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 10,
    parameter int unsigned LAST_ADDR = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    instr_encode_writer_if.slave bus,
    output logic [ADDR_W-1:0]    wr_ptr,
    output logic                 done,
    output logic                 full,
    output logic                 err_illegal
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]          csum
`endif
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU  = 5'd3,
        OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_SLL  = 5'd6,  OP_SRL   = 5'd7,
        OP_SLT  = 5'd8,  OP_JR   = 5'd9,  OP_ADDI = 5'd10, OP_ADDIU = 5'd11,
        OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_LW   = 5'd14, OP_SW    = 5'd15,
        OP_BEQ  = 5'd16, OP_BNE  = 5'd17, OP_J    = 5'd18, OP_JAL   = 5'd19,
        OP_SLTI = 5'd20, OP_HALT = 5'd21
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_FULL} state_e;

    state_e      state;
    logic        pend_halt;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        enc_halt;
    logic [31:0] r_base;
    logic [31:0] i_base;

    assign r_base = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 11'd0};
    assign i_base = {6'b000000, bus.in_rs, bus.in_rt, bus.in_imm};

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        enc_halt  = 1'b0;
        case (op_e'(bus.in_op))
            OP_ADD:   enc_word = r_base | 32'h20;
            OP_ADDU:  enc_word = r_base | 32'h21;
            OP_SUB:   enc_word = r_base | 32'h22;
            OP_SUBU:  enc_word = r_base | 32'h23;
            OP_AND:   enc_word = r_base | 32'h24;
            OP_OR:    enc_word = r_base | 32'h25;
            OP_SLL:   enc_word = r_base | {21'd0, bus.in_shamt, 6'b000000};
            OP_SRL:   enc_word = r_base | {21'd0, bus.in_shamt, 6'b000010};
            OP_SLT:   enc_word = r_base | 32'h2A;
            OP_JR:    enc_word = {6'b000000, bus.in_rs, 15'd0, 6'b001000};
            OP_ADDI:  enc_word = i_base | {6'b001000, 26'd0};
            OP_ADDIU: enc_word = i_base | {6'b001001, 26'd0};
            OP_ANDI:  enc_word = i_base | {6'b001100, 26'd0};
            OP_ORI:   enc_word = i_base | {6'b001101, 26'd0};
            OP_LW:    enc_word = i_base | {6'b100011, 26'd0};
            OP_SW:    enc_word = i_base | {6'b101011, 26'd0};
            OP_BEQ:   enc_word = i_base | {6'b000100, 26'd0};
            OP_BNE:   enc_word = i_base | {6'b000101, 26'd0};
            OP_SLTI:  enc_word = i_base | {6'b001010, 26'd0};
            OP_J:     enc_word = {6'b000010, bus.in_target};
            OP_JAL:   enc_word = {6'b000011, bus.in_target};
            OP_HALT: begin
                enc_word = {6'b111111, 26'd0};
                enc_halt = 1'b1;
            end
            default:  enc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            wr_ptr        <= BASE;
            done          <= 1'b0;
            full          <= 1'b0;
            err_illegal   <= 1'b0;
            pend_halt     <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            csum          <= '0;
`endif
        end else if (clear) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
            bus.mem_we   <= 1'b0;
            wr_ptr       <= BASE;
            done         <= 1'b0;
            full         <= 1'b0;
            err_illegal  <= 1'b0;
            pend_halt    <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (enc_legal) begin
                            state         <= S_WRITE;
                            bus.in_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= wr_ptr;
                            bus.mem_wdata <= enc_word;
                            pend_halt     <= enc_halt;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ready) begin
                        bus.mem_we <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                        csum <= csum ^ bus.mem_wdata;
`endif
                        // Pointer saturates at LAST: the FULL state is what stops further writes.
                        if (wr_ptr == LAST) begin
                            full <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                        if (pend_halt) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (wr_ptr == LAST) begin
                            state <= S_FULL;
                        end else begin
                            state        <= S_IDLE;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encode_writer.sv
// Directed self-checking bench for instr_encode_writer (default and near-full instances).
module tb_instr_encode_writer;
    localparam logic [4:0] ADD = 5'd0, SLL = 5'd6, JR = 5'd9, ADDI = 5'd10, LW = 5'd14,
                           BNE = 5'd17, J = 5'd18, HALT = 5'd21;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] wr_ptr, wr_ptr_f;
    logic       done, full, err_illegal;
    logic       done_f, full_f, err_illegal_f;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] csum, csum_f;
`endif
    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wr_count_f = 0;
    logic [9:0] last_addr_f = '0;

    instr_encode_writer_if #(.ADDR_W(10)) bus ();
    instr_encode_writer_if #(.ADDR_W(10)) busf ();

    instr_encode_writer #(.ADDR_W(10), .BASE_ADDR(10), .LAST_ADDR(1023)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .wr_ptr(wr_ptr), .done(done), .full(full), .err_illegal(err_illegal)
`ifdef ENC_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    instr_encode_writer #(.ADDR_W(10), .BASE_ADDR(1022), .LAST_ADDR(1023)) u_full (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(busf),
        .wr_ptr(wr_ptr_f), .done(done_f), .full(full_f), .err_illegal(err_illegal_f)
`ifdef ENC_CHECKSUM_EN
        , .csum(csum_f)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_ready) wr_count <= wr_count + 1;
        if (busf.mem_we && busf.mem_ready) begin
            wr_count_f  <= wr_count_f + 1;
            last_addr_f <= busf.mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt);
        logic acc;
        acc = 1'b0;
        bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    // Sends one instruction with mem_ready high and checks the resulting single write.
    task automatic write_word(input string tag, input logic [4:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                              input logic [15:0] imm, input logic [25:0] tgt,
                              input logic [31:0] exp_word, input logic [9:0] exp_addr);
        bus.mem_ready = 1'b1;
        send(op, rs, rt, rd, sh, imm, tgt);
        check({tag, "_we"}, {31'd0, bus.mem_we}, 32'd1);
        check({tag, "_addr"}, {22'd0, bus.mem_addr}, {22'd0, exp_addr});
        check({tag, "_wdata"}, bus.mem_wdata, exp_word);
        step();
        check({tag, "_we_drop"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_wr_ptr"}, {22'd0, wr_ptr}, {22'd0, exp_addr + 10'd1});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int base_cnt;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0; bus.mem_ready = 1'b1;
        busf.in_valid = 1'b0; busf.in_op = '0; busf.in_rs = '0; busf.in_rt = '0; busf.in_rd = '0;
        busf.in_shamt = '0; busf.in_imm = '0; busf.in_target = '0; busf.mem_ready = 1'b1;

        #12;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_wr_ptr", {22'd0, wr_ptr}, 32'd10);
        check("rst_flags", {29'd0, done, full, err_illegal}, 32'd0);
        check("rst_wr_ptr_f", {22'd0, wr_ptr_f}, 32'd1022);
`ifdef ENC_CHECKSUM_EN
        check("rst_csum", csum, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Test 1: ADD rd=1, in_ready returns after the write
        send(ADD, 5'd0, 5'd0, 5'd1, 5'd0, 16'd0, 26'd0);
        check("t1_we", {31'd0, bus.mem_we}, 32'd1);
        check("t1_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        check("t1_addr", {22'd0, bus.mem_addr}, 32'd10);
        check("t1_wdata", bus.mem_wdata, 32'h00000820);
        step();
        check("t1_we_drop", {31'd0, bus.mem_we}, 32'd0);
        check("t1_wr_ptr", {22'd0, wr_ptr}, 32'd11);
        check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Test 2: ADDI then LW from a cleared pointer
        do_clear();
        check("clr_wr_ptr", {22'd0, wr_ptr}, 32'd10);
        write_word("t2_addi", ADDI, 5'd7, 5'd7, 5'd0, 5'd0, 16'd9, 26'd0, 32'h20E70009, 10'd10);
        write_word("t2_lw", LW, 5'd16, 5'd9, 5'd0, 5'd0, 16'd0, 26'd0, 32'h8E090000, 10'd11);
`ifdef ENC_CHECKSUM_EN
        check("t2_csum", csum, 32'hAEEE0009);
`endif

        // Field forcing and other formats
        write_word("sll", SLL, 5'd0, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'd0, 32'h00021900, 10'd12);
        write_word("jr", JR, 5'd31, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'd0, 32'h03E00008, 10'd13);
        write_word("j", J, 5'd1, 5'd2, 5'd3, 5'd4, 16'd0, 26'h3FFFFFF, 32'h0BFFFFFF, 10'd14);
        write_word("add_sh", ADD, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0, 32'h00221820, 10'd15);

        // Test 3: BNE with memory stalled for three cycles
        base_cnt = wr_count;
        bus.mem_ready = 1'b0;
        send(BNE, 5'd0, 5'd11, 5'd0, 5'd0, 16'd21, 26'd0);
        check("t3_wdata", bus.mem_wdata, 32'h140B0015);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_we", {31'd0, bus.mem_we}, 32'd1);
            check("t3_hold_addr", {22'd0, bus.mem_addr}, 32'd16);
            check("t3_hold_wdata", bus.mem_wdata, 32'h140B0015);
        end
        bus.mem_ready = 1'b1;
        step();
        check("t3_we_drop", {31'd0, bus.mem_we}, 32'd0);
        check("t3_wr_ptr", {22'd0, wr_ptr}, 32'd17);
        check("t3_one_write", wr_count - base_cnt, 32'd1);

        // Test 4: HALT, input blocked, then clear
        send(HALT, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 26'd0);
        check("t4_wdata", bus.mem_wdata, 32'hFC000000);
        check("t4_addr", {22'd0, bus.mem_addr}, 32'd17);
        step();
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_full", {31'd0, full}, 32'd0);
        check("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
        base_cnt = wr_count;
        bus.in_op = ADD;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.in_valid = 1'b0;
        check("t4_blocked_we", {31'd0, bus.mem_we}, 32'd0);
        check("t4_blocked_cnt", wr_count - base_cnt, 32'd0);
        check("t4_done_sticky", {31'd0, done}, 32'd1);
        do_clear();
        check("t4_clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t4_clr_wr_ptr", {22'd0, wr_ptr}, 32'd10);
        check("t4_clr_done", {31'd0, done}, 32'd0);

        // Test 5a: illegal op is dropped
        send(5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
        check("t5_no_we", {31'd0, bus.mem_we}, 32'd0);
        check("t5_err", {31'd0, err_illegal}, 32'd1);
        check("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t5_wr_ptr", {22'd0, wr_ptr}, 32'd10);

        // Test 5b: near-full instance takes two words then refuses input
        busf.in_op = ADD;
        busf.in_rd = 5'd1;
        busf.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("t5_full", {31'd0, full_f}, 32'd1);
        check("t5_full_done", {31'd0, done_f}, 32'd0);
        check("t5_full_cnt", wr_count_f, 32'd2);
        check("t5_full_last", {22'd0, last_addr_f}, 32'd1023);
        check("t5_full_in_ready", {31'd0, busf.in_ready}, 32'd0);
        check("t5_full_we", {31'd0, busf.mem_we}, 32'd0);
        busf.in_valid = 1'b0;

        // Test 6: async reset during a stalled write
        write_word("t6_pre", ADD, 5'd0, 5'd0, 5'd1, 5'd0, 16'd0, 26'd0, 32'h00000820, 10'd10);
        bus.mem_ready = 1'b0;
        send(ADD, 5'd0, 5'd0, 5'd2, 5'd0, 16'd0, 26'd0);
        check("t6_we_pending", {31'd0, bus.mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_we", {31'd0, bus.mem_we}, 32'd0);
        check("t6_wr_ptr", {22'd0, wr_ptr}, 32'd10);
        check("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t6_err_cleared", {31'd0, err_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
